// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: control bundle layout and MIPS opcodes.
package pipeline_defs;

  localparam int CTRL_W        = 12;
  localparam int CTRL_MEMREAD  = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMWRITE = 2;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_SH       = 6'b101001;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_LW       = 6'b100011;

  // True when the opcode reads rt as a source (everything else reads rs only).
  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    case (op)
      OP_RTYPE, OP_SPECIAL2, OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE: r = 1'b1;
      default:                                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: load in EX whose rt feeds the ID instruction.
module hazard_detect
  import pipeline_defs::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard_raw
);

  // Register 0 is never a real dependency; rt only matters for rt readers.
  always_comb begin
    hazard_raw = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (uses_rt(id_opcode) && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use stall, flush bubble and stall counter.
module id_ex_register
  import pipeline_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = pipeline_defs::CTRL_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic [5:0]        ID_opcode,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic [4:0]        ID_rd,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [DATA_W-1:0] ID_PCPlus4,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  output logic [5:0]        EX_opcode,
  output logic [4:0]        EX_rs,
  output logic [4:0]        EX_rt,
  output logic [4:0]        EX_rd,
  output logic [DATA_W-1:0] EX_ReadData1,
  output logic [DATA_W-1:0] EX_ReadData2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [DATA_W-1:0] EX_PCPlus4,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              Stall,
  output logic [31:0]       StallCount
);

  logic [5:0]        opcode_q, opcode_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              hazard_raw;
  logic              bubble;

  hazard_detect u_hazard (
    .ex_mem_read (ctrl_q[CTRL_MEMREAD]),
    .ex_rt       (rt_q),
    .id_opcode   (ID_opcode),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .hazard_raw  (hazard_raw)
  );

  // Flush overrides the stall: the squashed instruction needs no hold.
  always_comb begin
    Stall     = hazard_raw & ~Flush;
    PCWrite   = ~Stall;
    IFIDWrite = ~Stall;
    bubble    = Flush | Stall;
  end

  // Next EX state: all-zero bubble on flush/stall, otherwise capture ID.
  always_comb begin
    opcode_d    = ID_opcode;
    rs_d        = ID_rs;
    rt_d        = ID_rt;
    rd_d        = ID_rd;
    rd1_d       = ID_ReadData1;
    rd2_d       = ID_ReadData2;
    imm_d       = ID_Imm;
    pc4_d       = ID_PCPlus4;
    ctrl_d      = ID_Ctrl;
    stall_cnt_d = stall_cnt_q;
    if (bubble) begin
      opcode_d = '0;
      rs_d     = '0;
      rt_d     = '0;
      rd_d     = '0;
      rd1_d    = '0;
      rd2_d    = '0;
      imm_d    = '0;
      pc4_d    = '0;
      ctrl_d   = '0;
    end
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Pipeline register and counter, cleared asynchronously by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      opcode_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      opcode_q    <= opcode_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign EX_opcode    = opcode_q;
  assign EX_rs        = rs_q;
  assign EX_rt        = rt_q;
  assign EX_rd        = rd_q;
  assign EX_ReadData1 = rd1_q;
  assign EX_ReadData2 = rd2_q;
  assign EX_Imm       = imm_q;
  assign EX_PCPlus4   = pc4_q;
  assign EX_Ctrl      = ctrl_q;
  assign StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed + random bench for id_ex_register against an instruction-level model.
module tb_id_ex_register;
  localparam int DW = 32;
  localparam int CW = 12;

  logic          Clk = 1'b0;
  logic          Reset, Flush;
  logic [5:0]    ID_opcode, EX_opcode;
  logic [4:0]    ID_rs, ID_rt, ID_rd, EX_rs, EX_rt, EX_rd;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4;
  logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4;
  logic [CW-1:0] ID_Ctrl, EX_Ctrl;
  logic          PCWrite, IFIDWrite, Stall;
  logic [31:0]   StallCount;

  id_ex_register #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .ID_opcode(ID_opcode), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PCPlus4(ID_PCPlus4), .ID_Ctrl(ID_Ctrl),
    .EX_opcode(EX_opcode), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_PCPlus4(EX_PCPlus4), .EX_Ctrl(EX_Ctrl),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Stall(Stall),
    .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  // Model: the instruction expected in EX, as a whole record.
  typedef struct {
    logic [5:0] op; logic [4:0] rs, rt, rd;
    logic [DW-1:0] a, b, imm, pc4; logic [CW-1:0] ctrl;
  } instr_t;

  instr_t m_ex;
  int unsigned m_cnt;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [CW-1:0] C_LW  = 12'h003;  // MemRead + RegWrite
  localparam logic [CW-1:0] C_ALU = 12'h002;  // RegWrite only

  function automatic instr_t nop();
    instr_t n;
    n.op = 0; n.rs = 0; n.rt = 0; n.rd = 0;
    n.a = 0; n.b = 0; n.imm = 0; n.pc4 = 0; n.ctrl = 0;
    return n;
  endfunction

  function automatic logic reads_rt(logic [5:0] op);
    return op inside {6'h00, 6'h1C, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h05};
  endfunction

  // A load in EX stalls the ID instruction when ID consumes its rt (not $0).
  function automatic logic exp_stall();
    logic dep;
    dep = (m_ex.rt == ID_rs) || (reads_rt(ID_opcode) && m_ex.rt == ID_rt);
    return m_ex.ctrl[0] && m_ex.rt != 0 && dep && !Flush;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(string tag);
    logic s;
    s = exp_stall();
    chk({tag, ":Stall"}, 32'(Stall), 32'(s));
    chk({tag, ":PCWrite"}, 32'(PCWrite), 32'(!s));
    chk({tag, ":IFIDWrite"}, 32'(IFIDWrite), 32'(!s));
  endtask

  task automatic chk_ex(string tag);
    chk({tag, ":op"}, 32'(EX_opcode), 32'(m_ex.op));
    chk({tag, ":rs"}, 32'(EX_rs), 32'(m_ex.rs));
    chk({tag, ":rt"}, 32'(EX_rt), 32'(m_ex.rt));
    chk({tag, ":rd"}, 32'(EX_rd), 32'(m_ex.rd));
    chk({tag, ":rd1"}, EX_ReadData1, m_ex.a);
    chk({tag, ":rd2"}, EX_ReadData2, m_ex.b);
    chk({tag, ":imm"}, EX_Imm, m_ex.imm);
    chk({tag, ":pc4"}, EX_PCPlus4, m_ex.pc4);
    chk({tag, ":ctrl"}, 32'(EX_Ctrl), 32'(m_ex.ctrl));
    chk({tag, ":cnt"}, StallCount, m_cnt);
  endtask

  task automatic set_id(logic [5:0] op, logic [4:0] rs, rt, rd, logic [CW-1:0] ctrl);
    ID_opcode = op; ID_rs = rs; ID_rt = rt; ID_rd = rd; ID_Ctrl = ctrl;
    ID_ReadData1 = $urandom; ID_ReadData2 = $urandom;
    ID_Imm = $urandom; ID_PCPlus4 = $urandom & 32'hFFFF_FFFC;
  endtask

  // One clock: check combinational outputs, clock, advance model, check EX.
  task automatic step(string tag);
    logic s;
    #1 chk_comb(tag);
    s = exp_stall();
    @(posedge Clk);
    if (Flush || s) m_ex = nop();
    else begin
      m_ex.op = ID_opcode; m_ex.rs = ID_rs; m_ex.rt = ID_rt; m_ex.rd = ID_rd;
      m_ex.a = ID_ReadData1; m_ex.b = ID_ReadData2; m_ex.imm = ID_Imm;
      m_ex.pc4 = ID_PCPlus4; m_ex.ctrl = ID_Ctrl;
    end
    if (s && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    #1 chk_ex(tag);
  endtask

  initial begin
    logic [31:0] cnt_before;
    Reset = 1'b0; Flush = 1'b0;
    set_id(6'h00, 0, 0, 0, 0);
    m_ex = nop(); m_cnt = 0;
    #3 chk_ex("reset"); chk_comb("reset");
    @(negedge Clk) Reset = 1'b1;

    // Load-use on rs: exactly one bubble, then the held add enters EX.
    set_id(6'h23, 5'd1, 5'd8, 5'd0, C_LW);        step("lw8");
    set_id(6'h00, 5'd8, 5'd10, 5'd9, C_ALU);
    #1 chk("rs_stall_seen", 32'(Stall), 32'd1);
    step("add_stall");
    chk("bubble_op", 32'(EX_opcode), 32'd0);
    chk("bubble_ctrl", 32'(EX_Ctrl), 32'd0);
    step("add_go");
    chk("add_rs", 32'(EX_rs), 32'd8);
    chk("add_rt", 32'(EX_rt), 32'd10);
    chk("cnt_one", StallCount, 32'd1);

    // rs-only opcodes: addi matching rs stalls, ori matching only rt does not.
    set_id(6'h23, 5'd1, 5'd8, 5'd0, C_LW);        step("lw8b");
    set_id(6'h08, 5'd8, 5'd9, 5'd0, C_ALU);       step("addi_stall");
    step("addi_go");
    set_id(6'h23, 5'd1, 5'd8, 5'd0, C_LW);        step("lw8c");
    set_id(6'h0D, 5'd10, 5'd8, 5'd0, C_ALU);
    #1 chk("ori_nostall", 32'(Stall), 32'd0);
    step("ori");

    // Register zero never stalls; store data dependency does.
    set_id(6'h23, 5'd1, 5'd0, 5'd0, C_LW);        step("lw0");
    set_id(6'h2B, 5'd0, 5'd0, 5'd0, 12'h004);
    #1 chk("sw0_nostall", 32'(Stall), 32'd0);
    step("sw0");
    set_id(6'h23, 5'd1, 5'd8, 5'd0, C_LW);        step("lw8d");
    set_id(6'h2B, 5'd9, 5'd8, 5'd0, 12'h004);
    #1 chk("sw8_stall", 32'(Stall), 32'd1);
    step("sw8_stall");
    step("sw8_go");

    // Flush beats the hazard: no stall, bubble loaded, counter unchanged.
    set_id(6'h23, 5'd1, 5'd8, 5'd0, C_LW);        step("lw8e");
    cnt_before = StallCount;
    set_id(6'h00, 5'd8, 5'd10, 5'd9, C_ALU); Flush = 1'b1;
    #1 chk("flush_stall", 32'(Stall), 32'd0);
    chk("flush_pcw", 32'(PCWrite), 32'd1);
    step("flush");
    chk("flush_cnt", StallCount, cnt_before);
    chk("flush_op", 32'(EX_opcode), 32'd0);
    Flush = 1'b0;

    // Pass-through of independent R-types.
    for (int i = 0; i < 10; i++) begin
      set_id(6'h00, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
             5'($urandom_range(1, 31)), C_ALU | CW'($urandom & 12'hFF8));
      step("rtype");
    end

    // Random mix on a small register set to provoke hazards.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] ops [8] = '{6'h23, 6'h00, 6'h1C, 6'h2B, 6'h08, 6'h0D, 6'h04, 6'h29};
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      set_id(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             (op == 6'h23) ? C_LW : CW'($urandom & 12'hFFE));
      Flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end
    Flush = 1'b0;

    // Reset asserted while a stall is being requested.
    set_id(6'h23, 5'd1, 5'd8, 5'd0, C_LW);        step("lw8f");
    set_id(6'h00, 5'd8, 5'd10, 5'd9, C_ALU);
    #1 chk("pre_reset_stall", 32'(Stall), 32'd1);
    Reset = 1'b0;
    #1 m_ex = nop(); m_cnt = 0;
    chk_ex("mid_reset");
    chk("mid_reset_stall", 32'(Stall), 32'd0);
    chk("mid_reset_pcw", 32'(PCWrite), 32'd1);
    @(negedge Clk) Reset = 1'b1;
    set_id(6'h00, 5'd3, 5'd4, 5'd5, C_ALU);       step("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
